// File: rtl/datapath_pkg.sv
// Shared types for the scratchpad command decoder: command op encoding,
// the 38-bit FIFO entry layout and the decoder FSM states.
package datapath_pkg;

  typedef enum logic [1:0] {
    OP_ILLEGAL = 2'b00,
    OP_LOAD    = 2'b01,
    OP_STORE   = 2'b10,
    OP_GEMM    = 2'b11
  } spad_op_t;

  typedef struct packed {
    spad_op_t    op;
    logic [3:0]  mat;
    logic [31:0] payload;
  } spad_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    STORE = 2'b10,
    GEMM  = 2'b11
  } spad_state_t;

  localparam int CMD_W = $bits(spad_cmd_t);

endpackage

// File: rtl/spad_row_addr_gen.sv
// Tile row counter plus row address generator: addr = base + row*ROW_BYTES,
// wrapping modulo 2^32.
module spad_row_addr_gen #(
  parameter int MAT_ROWS  = 4,
  parameter int ROW_BYTES = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        advance,
  input  logic [31:0]                 base,
  output logic [$clog2(MAT_ROWS)-1:0] row,
  output logic                        last,
  output logic [31:0]                 addr
);

  localparam int ROW_W = $clog2(MAT_ROWS);

  logic [ROW_W-1:0] row_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_reg <= '0;
    end else if (clear) begin
      row_reg <= '0;
    end else if (advance) begin
      row_reg <= row_reg + 1'b1;
    end
  end

  assign row  = row_reg;
  assign last = (row_reg == ROW_W'(MAT_ROWS - 1));
  // Truncation to 32 bits gives the required address wrap for free.
  assign addr = base + (32'(row_reg) * 32'(ROW_BYTES));

endmodule

// File: rtl/spad_cmd_decoder.sv
// Scratchpad command decoder: pops FIFO commands and sequences per-row memory
// requests or a single GEMM issue. Define SPAD_PERF_CNT_EN for perf counters.
module spad_cmd_decoder
  import datapath_pkg::*;
#(
  parameter int MAT_ROWS  = 4,
  parameter int ROW_BYTES = 8
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        fifo_empty,
  input  logic [37:0]                 fifo_rdata,
  output logic                        fifo_ren,
  output logic                        mem_req,
  output logic                        mem_wen,
  output logic [31:0]                 mem_addr,
  output logic [3:0]                  mem_mat,
  output logic [$clog2(MAT_ROWS)-1:0] mem_row,
  input  logic                        mem_ready,
  output logic                        gemm_valid,
  output logic                        gemm_new_weight,
  output logic [15:0]                 gemm_sel,
  input  logic                        gemm_ready,
  output logic                        busy,
  output logic                        err_op
`ifdef SPAD_PERF_CNT_EN
  ,
  output logic [31:0]                 perf_ld_cnt,
  output logic [31:0]                 perf_st_cnt,
  output logic [31:0]                 perf_gemm_cnt
`endif
);

  localparam int ROW_W = $clog2(MAT_ROWS);

  spad_state_t state_reg, state_next;
  spad_cmd_t   head;
  logic [3:0]  mat_reg;
  logic [31:0] payload_reg;
  logic        err_reg;

  logic             mem_active;
  logic             mem_hs;
  logic             row_last;
  logic [ROW_W-1:0] row;
  logic [31:0]      row_addr;

  assign head = spad_cmd_t'(fifo_rdata);

  // fifo_ren is gated by nRST so that no pop is presented while in reset.
  always_comb begin
    state_next = state_reg;
    fifo_ren   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty && nRST) begin
          fifo_ren = 1'b1;
          case (head.op)
            OP_LOAD:  state_next = LOAD;
            OP_STORE: state_next = STORE;
            OP_GEMM:  state_next = GEMM;
            default:  state_next = IDLE;
          endcase
        end
      end
      LOAD, STORE: begin
        if (mem_hs && row_last) state_next = IDLE;
      end
      GEMM: begin
        if (gemm_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg   <= IDLE;
      mat_reg     <= '0;
      payload_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= fifo_ren && (head.op == OP_ILLEGAL);
      if (fifo_ren) begin
        mat_reg     <= head.mat;
        payload_reg <= head.payload;
      end
    end
  end

  spad_row_addr_gen #(
    .MAT_ROWS (MAT_ROWS),
    .ROW_BYTES(ROW_BYTES)
  ) u_row_addr_gen (
    .clk    (CLK),
    .rst_n  (nRST),
    .clear  (fifo_ren),
    .advance(mem_hs),
    .base   (payload_reg),
    .row    (row),
    .last   (row_last),
    .addr   (row_addr)
  );

  assign mem_active = (state_reg == LOAD) || (state_reg == STORE);
  assign mem_hs     = mem_active && mem_ready;

  assign mem_req  = mem_active;
  assign mem_wen  = (state_reg == STORE);
  assign mem_addr = mem_active ? row_addr : '0;
  assign mem_mat  = mem_active ? mat_reg : '0;
  assign mem_row  = mem_active ? row : '0;

  // mat[3] selects a fresh weight load; mat[2:0] and payload[31:16] are don't-care here.
  assign gemm_valid      = (state_reg == GEMM);
  assign gemm_new_weight = gemm_valid && mat_reg[3];
  assign gemm_sel        = gemm_valid ? payload_reg[15:0] : '0;

  assign busy   = (state_reg != IDLE);
  assign err_op = err_reg;

`ifdef SPAD_PERF_CNT_EN
  logic [31:0] ld_cnt_reg, st_cnt_reg, gemm_cnt_reg;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ld_cnt_reg   <= '0;
      st_cnt_reg   <= '0;
      gemm_cnt_reg <= '0;
    end else begin
      if ((state_reg == LOAD) && mem_hs && row_last)  ld_cnt_reg   <= ld_cnt_reg + 1'b1;
      if ((state_reg == STORE) && mem_hs && row_last) st_cnt_reg   <= st_cnt_reg + 1'b1;
      if (gemm_valid && gemm_ready)                   gemm_cnt_reg <= gemm_cnt_reg + 1'b1;
    end
  end

  assign perf_ld_cnt   = ld_cnt_reg;
  assign perf_st_cnt   = st_cnt_reg;
  assign perf_gemm_cnt = gemm_cnt_reg;
`endif

endmodule

// File: tb/tb_spad_cmd_decoder.sv
// Randomised self-checking bench for spad_cmd_decoder: a queue-based FIFO and a
// transaction-level expectation model (per-command beat lists) judge every cycle.
module tb_spad_cmd_decoder;

  localparam int MAT_ROWS  = 4;
  localparam int ROW_BYTES = 8;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [37:0] fifo_rdata = '0;
  logic        fifo_ren;
  logic        mem_req, mem_wen;
  logic [31:0] mem_addr;
  logic [3:0]  mem_mat;
  logic [1:0]  mem_row;
  logic        mem_ready = 1'b0;
  logic        gemm_valid, gemm_new_weight;
  logic [15:0] gemm_sel;
  logic        gemm_ready = 1'b0;
  logic        busy, err_op;
`ifdef SPAD_PERF_CNT_EN
  logic [31:0] perf_ld_cnt, perf_st_cnt, perf_gemm_cnt;
`endif

  spad_cmd_decoder #(.MAT_ROWS(MAT_ROWS), .ROW_BYTES(ROW_BYTES)) dut (
    .CLK(CLK), .nRST(nRST),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_ren(fifo_ren),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_mat(mem_mat),
    .mem_row(mem_row), .mem_ready(mem_ready),
    .gemm_valid(gemm_valid), .gemm_new_weight(gemm_new_weight), .gemm_sel(gemm_sel),
    .gemm_ready(gemm_ready), .busy(busy), .err_op(err_op)
`ifdef SPAD_PERF_CNT_EN
    , .perf_ld_cnt(perf_ld_cnt), .perf_st_cnt(perf_st_cnt), .perf_gemm_cnt(perf_gemm_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [3:0]  mat;
    logic [1:0]  row;
  } beat_t;

  logic [37:0] fifo_q[$];
  beat_t       beats[$];
  int          m_kind = 0;       // 0 idle, 1 memory command, 2 gemm
  int          m_left = 0;
  bit          m_store = 0;
  bit          m_err = 0;
  int          m_gcnt = 0;
  int          m_gdelay = 0;
  logic        g_nw;
  logic [15:0] g_sel;
  int          exp_ld = 0, exp_st = 0, exp_gm = 0;
  int          ready_mode = 0;   // 0 always, 1 every 3rd cycle, 2 random
  int          gdelay_cfg = 0;   // <0: random per gemm
  bit          rst_req = 0;
  int          cyc = 0;

  task automatic check_zero(input string tag);
    check_val({tag, "_ren"}, 32'(fifo_ren), 0);
    check_val({tag, "_mreq"}, 32'(mem_req), 0);
    check_val({tag, "_mwen"}, 32'(mem_wen), 0);
    check_val({tag, "_maddr"}, mem_addr, 0);
    check_val({tag, "_mmat"}, 32'(mem_mat), 0);
    check_val({tag, "_mrow"}, 32'(mem_row), 0);
    check_val({tag, "_gval"}, 32'(gemm_valid), 0);
    check_val({tag, "_gnw"}, 32'(gemm_new_weight), 0);
    check_val({tag, "_gsel"}, 32'(gemm_sel), 0);
    check_val({tag, "_busy"}, 32'(busy), 0);
    check_val({tag, "_err"}, 32'(err_op), 0);
`ifdef SPAD_PERF_CNT_EN
    check_val({tag, "_pld"}, perf_ld_cnt, 0);
    check_val({tag, "_pst"}, perf_st_cnt, 0);
    check_val({tag, "_pgm"}, perf_gemm_cnt, 0);
`endif
  endtask

  task automatic model_reset();
    beats.delete();
    m_kind = 0; m_left = 0; m_err = 0;
    exp_ld = 0; exp_st = 0; exp_gm = 0;
  endtask

  task automatic check_counters(input string tag);
`ifdef SPAD_PERF_CNT_EN
    check_val({tag, "_ld_cnt"}, perf_ld_cnt, 32'(exp_ld));
    check_val({tag, "_st_cnt"}, perf_st_cnt, 32'(exp_st));
    check_val({tag, "_gm_cnt"}, perf_gemm_cnt, 32'(exp_gm));
`else
    check_val({tag, "_busy_end"}, 32'(busy), 0);
`endif
  endtask

  task automatic run_cycle();
    bit          pop;
    bit          err_next;
    logic [37:0] c;
    logic [1:0]  op;
    logic [31:0] pl;
    logic [3:0]  mt;
    beat_t       b;
    @(negedge CLK);
    cyc++;
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = fifo_empty ? {6'($urandom), 32'($urandom)} : fifo_q[0];
    case (ready_mode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = (cyc % 3 == 0);
      default: mem_ready = 1'($urandom_range(0, 1));
    endcase
    gemm_ready = (m_kind == 2) ? (m_gcnt >= m_gdelay) : 1'($urandom_range(0, 1));
    #1;
    pop = (m_kind == 0) && (fifo_q.size() > 0);
    check_val("fifo_ren", 32'(fifo_ren), 32'(pop));
    check_val("mem_req", 32'(mem_req), 32'(m_kind == 1));
    check_val("gemm_valid", 32'(gemm_valid), 32'(m_kind == 2));
    check_val("busy", 32'(busy), 32'(m_kind != 0));
    check_val("err_op", 32'(err_op), 32'(m_err));
    check_val("req_exclusive", 32'(mem_req && gemm_valid), 0);
    if (m_kind == 1 && beats.size() > 0) begin
      check_val("mem_addr", mem_addr, beats[0].addr);
      check_val("mem_mat", 32'(mem_mat), 32'(beats[0].mat));
      check_val("mem_row", 32'(mem_row), 32'(beats[0].row));
      check_val("mem_wen", 32'(mem_wen), 32'(beats[0].wen));
    end
    if (m_kind == 2) begin
      check_val("gemm_new_weight", 32'(gemm_new_weight), 32'(g_nw));
      check_val("gemm_sel", 32'(gemm_sel), 32'(g_sel));
    end
    $display("cyc %0d ren=%0b mreq=%0b addr=%h row=%0d gval=%0b err=%0b",
             cyc, fifo_ren, mem_req, mem_addr, mem_row, gemm_valid, err_op);

    if (rst_req && m_kind == 1 && beats.size() > 0 && beats[0].row == 2'd2) begin
      rst_req = 0;
      #1 nRST = 1'b0;
      #1 check_zero("rst_mid");
      model_reset();
      @(posedge CLK);
      #2 nRST = 1'b1;
      return;
    end

    err_next = 0;
    if (m_kind == 1) begin
      if (mem_ready) begin
        void'(beats.pop_front());
        m_left--;
        if (m_left == 0) begin
          if (m_store) exp_st++; else exp_ld++;
          m_kind = 0;
        end
      end
    end else if (m_kind == 2) begin
      if (gemm_ready) begin
        exp_gm++;
        m_kind = 0;
      end else begin
        m_gcnt++;
      end
    end else if (pop) begin
      c  = fifo_q[0];
      op = c[37:36];
      mt = c[35:32];
      pl = c[31:0];
      if (op == 2'b01 || op == 2'b10) begin
        m_kind  = 1;
        m_left  = MAT_ROWS;
        m_store = (op == 2'b10);
        for (int r = 0; r < MAT_ROWS; r++) begin
          b.wen  = m_store;
          b.addr = pl + 32'(r * ROW_BYTES);
          b.mat  = mt;
          b.row  = 2'(r);
          beats.push_back(b);
        end
      end else if (op == 2'b11) begin
        m_kind   = 2;
        m_gcnt   = 0;
        m_gdelay = (gdelay_cfg < 0) ? int'($urandom_range(0, 3)) : gdelay_cfg;
        g_nw     = mt[3];
        g_sel    = pl[15:0];
      end else begin
        err_next = 1;
      end
    end
    m_err = err_next;
    @(posedge CLK);
    if (pop) void'(fifo_q.pop_front());
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int n = 0;
    while ((fifo_q.size() != 0 || m_kind != 0 || m_err) && n < max_cycles) begin
      run_cycle();
      n++;
    end
    if (n >= max_cycles)
      check_val({tag, "_timeout"}, 32'(fifo_q.size()) + 32'(m_kind), 0);
    run_cycle();
    check_counters(tag);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge CLK);
    #2 nRST = 1'b0;
    #1 check_zero(tag);
    model_reset();
    @(posedge CLK);
    #2 nRST = 1'b1;
  endtask

  initial begin
    // Reset with a non-empty FIFO: nothing may be popped while nRST is low.
    fifo_empty = 1'b0;
    fifo_rdata = {2'b01, 4'h1, 32'h0};
    #3 check_zero("reset");
    @(posedge CLK);
    #2 nRST = 1'b1;

    ready_mode = 0;
    fifo_q.push_back({2'b01, 4'h3, 32'h0000_1000});
    drain("load", 50);

    ready_mode = 1;
    fifo_q.push_back({2'b10, 4'h5, 32'hFFFF_FFF8});
    drain("store_wrap", 50);

    ready_mode = 0;
    gdelay_cfg = 5;
    fifo_q.push_back({2'b11, 4'h8, 32'hABCD_1234});
    drain("gemm", 50);

    fifo_q.push_back({2'b00, 4'hF, 32'hDEAD_BEEF});
    fifo_q.push_back({2'b01, 4'h9, 32'h0000_0040});
    drain("illegal_then_load", 50);

    rst_req = 1;
    fifo_q.push_back({2'b01, 4'h2, 32'h0000_2000});
    fifo_q.push_back({2'b01, 4'h7, 32'h0000_3000});
    drain("reset_mid", 80);
    check_val("reset_mid_fired", 32'(rst_req), 0);

    pulse_reset("reset_idle");
    ready_mode = 2;
    gdelay_cfg = -1;
    fifo_q.push_back({2'b01, 4'h1, 32'h0000_0100});
    fifo_q.push_back({2'b11, 4'h0, 32'h5555_0001});
    fifo_q.push_back({2'b10, 4'h4, 32'h0000_0200});
    fifo_q.push_back({2'b11, 4'hC, 32'h0000_0002});
    fifo_q.push_back({2'b01, 4'h6, 32'hFFFF_FFF0});
    fifo_q.push_back({2'b11, 4'h8, 32'h0000_0003});
    drain("perf_mix", 200);
`ifdef SPAD_PERF_CNT_EN
    check_val("perf_ld_2", perf_ld_cnt, 32'd2);
    check_val("perf_st_1", perf_st_cnt, 32'd1);
    check_val("perf_gm_3", perf_gemm_cnt, 32'd3);
`endif

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0)
        fifo_q.push_back({2'($urandom), 4'($urandom), 32'($urandom)});
      run_cycle();
    end
    drain("random", 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spad_cmd_decoder.md
SPAD_CMD_DECODER -- requirements
Module: spad_cmd_decoder

Interface
REQ-001 SHALL have parameter MAT_ROWS, default 4, rows per matrix tile (power of two, >=2).
REQ-002 SHALL have parameter ROW_BYTES, default 8, byte pitch between consecutive tile rows.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: CLK  in  1  clock; nRST  in  1  async active-low reset.
REQ-004 SHALL have fifo_empty  in  1  command FIFO empty (first-word-fall-through read side).
REQ-005 SHALL have fifo_rdata  in  38  head entry {op[37:36], mat[35:32], payload[31:0]}.
REQ-006 SHALL have fifo_ren  out  1  pop head entry.
REQ-007 SHALL have mem_req  out  1; mem_wen  out  1 (1 store, 0 load); mem_addr  out  32; mem_mat  out  4; mem_row  out  $clog2(MAT_ROWS); mem_ready  in  1.
REQ-008 SHALL have gemm_valid  out  1; gemm_new_weight  out  1; gemm_sel  out  16 {rs1,rs2,rs3,rd}, 4 bits each; gemm_ready  in  1.
REQ-009 SHALL have busy  out  1 (state != IDLE) and err_op  out  1 (one-cycle pulse).

Function
REQ-010 Op encoding SHALL be: 2'b01 load, 2'b10 store, 2'b11 gemm, 2'b00 illegal.
REQ-011 FSM states SHALL be IDLE, LOAD, STORE, GEMM.
REQ-012 In IDLE with !fifo_empty, fifo_ren SHALL be 1 for exactly that cycle, and the head entry SHALL be latched at the same edge.
REQ-013 fifo_ren SHALL be 0 in every non-IDLE state; at most one pop per command.
REQ-014 Pop of op 01/10 SHALL go to LOAD/STORE with row=0; mem_req SHALL assert the next cycle (1-cycle pop-to-request latency).
REQ-015 In LOAD/STORE: mem_addr = payload + row*ROW_BYTES, mod 2^32 (wrap, no error); mem_mat = latched mat; mem_row = row; mem_wen = (state==STORE).
REQ-016 mem_req and all mem_* fields SHALL hold stable until mem_req && mem_ready; each such handshake SHALL advance row by 1.
REQ-017 Handshake on row MAT_ROWS-1 SHALL return to IDLE; mem_req SHALL be 0 the following cycle.
REQ-018 Pop of op 11 SHALL go to GEMM: gemm_new_weight = mat[3], gemm_sel = payload[15:0]; payload[31:16] and mat[2:0] SHALL be ignored.
REQ-019 gemm_valid SHALL hold with stable fields until gemm_ready, then return to IDLE.
REQ-020 Pop of op 00 SHALL pulse err_op the next cycle, stay in IDLE, and issue no request.
REQ-021 A new pop SHALL occur no earlier than the first cycle in IDLE after completion (no same-cycle overlap with the final handshake).
REQ-022 mem_req and gemm_valid SHALL never be 1 in the same cycle.

Reset
REQ-023 nRST low SHALL immediately force: state IDLE, row 0, latched entry 0, and all outputs 0 (fifo_ren, mem_*, gemm_*, busy, err_op, counters).
REQ-024 Reset mid-command SHALL abandon the command without a replay; the first pop after reset release SHALL occur no earlier than the first rising edge with nRST high.

Configuration
REQ-025 Macro SPAD_PERF_CNT_EN defined: add outputs perf_ld_cnt, perf_st_cnt, perf_gemm_cnt (32 each), each incrementing once per completed command (final handshake) with 2^32 wrap.
REQ-026 SPAD_PERF_CNT_EN undefined: these ports and counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 The op enum (spad_op_t), the 38-bit command struct (spad_cmd_t), and the FSM state enum SHALL live in datapath_pkg.
REQ-028 One sub-module, spad_row_addr_gen (row counter + address adder, MAT_ROWS/ROW_BYTES parameterised), SHALL be instantiated; the FSM stays in the top.

Verification
REQ-029 Load {01,4'h3,32'h0000_1000}, mem_ready=1 -> addrs 1000,1008,1010,1018 on consecutive cycles, mem_mat=3, mem_wen=0, then IDLE.
REQ-030 Store {10,4'h5,32'hFFFF_FFF8}, mem_ready high only every 3rd cycle -> addrs FFFFFFF8,00000000,00000008,00000010, fields stable while stalled.
REQ-031 Gemm {11,4'h8,32'hABCD_1234}, gemm_ready after 5 cycles -> gemm_new_weight=1, gemm_sel=16'h1234 held 5 cycles, no mem_req.
REQ-032 Op 00 then load back-to-back in FIFO -> err_op single pulse, load proceeds with its own fifo_ren, no request for the illegal entry.
REQ-033 nRST asserted during row 2 of a load -> all outputs 0 immediately; after release the next FIFO entry is popped, with no row-3 request.
REQ-034 With SPAD_PERF_CNT_EN: 2 loads, 1 store, 3 gemms -> counters 2/1/3; compile without the macro -> remaining checks pass unchanged.
